// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the state encoding, the MDU latency defaults and the MDU counter width.
package pipe_hazard_ctrl_pkg;

   localparam int CNT_W           = 6;
   localparam int MULT_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF  = 32;

   typedef enum logic {
      IDLE     = 1'b0,
      MDU_BUSY = 1'b1
   } hz_state_t;

   typedef struct packed {
      logic pa_pc;
      logic pa_ifid;
      logic pa_idexmemwr;
      logic wash_ifid;
      logic wash_idex;
   } hz_ctl_t;

   localparam hz_ctl_t CTL_NONE    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam hz_ctl_t CTL_FLUSH   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   localparam hz_ctl_t CTL_HOLD    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam hz_ctl_t CTL_LOADUSE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam hz_ctl_t CTL_BRANCH  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   // Counter preload for an MDU issue: the issue cycle itself is one of the latency cycles.
   function automatic logic [CNT_W-1:0] mdu_preload(input logic is_div,
                                                    input int   mult_cycles,
                                                    input int   div_cycles);
      int n;
      n = is_div ? div_cycles : mult_cycles;
      return (n > 0) ? CNT_W'(n - 1) : '0;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: stage info in, hold/wash controls out.
interface pipe_hazard_ctrl_if;
   logic [4:0]  id_rs_addr;
   logic [4:0]  id_rt_addr;
   logic        id_rs_used;
   logic        id_rt_used;
   logic        id_branch_taken;
   logic        ex_regwr;
   logic        ex_memtoreg;
   logic [4:0]  ex_regdst_addr;
   logic        mdu_start;
   logic        mdu_is_div;
   logic        dmem_wait;
   logic        exc_flush;
   logic        pa_pc;
   logic        pa_ifid;
   logic        pa_idexmemwr;
   logic        wash_ifid;
   logic        wash_idex;
   logic        mdu_busy;
   logic [31:0] stall_cnt;

   modport master (
      output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_branch_taken,
             ex_regwr, ex_memtoreg, ex_regdst_addr, mdu_start, mdu_is_div,
             dmem_wait, exc_flush,
      input  pa_pc, pa_ifid, pa_idexmemwr, wash_ifid, wash_idex, mdu_busy, stall_cnt
   );

   modport slave (
      input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_branch_taken,
             ex_regwr, ex_memtoreg, ex_regdst_addr, mdu_start, mdu_is_div,
             dmem_wait, exc_flush,
      output pa_pc, pa_ifid, pa_idexmemwr, wash_ifid, wash_idex, mdu_busy, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use compare: a load in EX feeding a register the ID instruction actually reads.
module load_use_detect (
   input  logic       ex_memtoreg,
   input  logic       ex_regwr,
   input  logic [4:0] ex_regdst_addr,
   input  logic [4:0] id_rs_addr,
   input  logic [4:0] id_rt_addr,
   input  logic       id_rs_used,
   input  logic       id_rt_used,
   output logic       load_use
);
   logic rs_hit;
   logic rt_hit;

   assign rs_hit = id_rs_used && (id_rs_addr == ex_regdst_addr);
   assign rt_hit = id_rt_used && (id_rt_addr == ex_regdst_addr);

   // r0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign load_use = ex_memtoreg && ex_regwr && (ex_regdst_addr != 5'd0) && (rs_hit || rt_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritised hold/wash generation, MDU wait FSM and stall counter.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   pipe_hazard_ctrl_if.slave hz
);
   hz_state_t        state;
   logic [CNT_W-1:0] mdu_cnt;
   logic [CNT_W-1:0] mdu_load;
   logic [31:0]      stall_cnt;
   logic             load_use;
   logic             mdu_issue;
   hz_ctl_t          ctl;

   load_use_detect u_load_use_detect (
      .ex_memtoreg    (hz.ex_memtoreg),
      .ex_regwr       (hz.ex_regwr),
      .ex_regdst_addr (hz.ex_regdst_addr),
      .id_rs_addr     (hz.id_rs_addr),
      .id_rt_addr     (hz.id_rt_addr),
      .id_rs_used     (hz.id_rs_used),
      .id_rt_used     (hz.id_rt_used),
      .load_use       (load_use)
   );

   assign mdu_load = mdu_preload(hz.mdu_is_div, MULT_CYCLES, DIV_CYCLES);

   // Branch sits below load-use, so a coincident branch is dropped and re-resolved next cycle.
   always_comb begin
      ctl       = CTL_NONE;
      mdu_issue = 1'b0;
      if (!reset)                  ctl = CTL_FLUSH;
      else if (hz.exc_flush)       ctl = CTL_FLUSH;
      else if (hz.dmem_wait)       ctl = CTL_HOLD;
      else if (state == MDU_BUSY)  ctl = CTL_HOLD;
      else if (hz.mdu_start) begin
         ctl       = CTL_HOLD;
         mdu_issue = 1'b1;
      end
      else if (load_use)           ctl = CTL_LOADUSE;
      else if (hz.id_branch_taken) ctl = CTL_BRANCH;
   end

   assign hz.pa_pc        = ctl.pa_pc;
   assign hz.pa_ifid      = ctl.pa_ifid;
   assign hz.pa_idexmemwr = ctl.pa_idexmemwr;
   assign hz.wash_ifid    = ctl.wash_ifid;
   assign hz.wash_idex    = ctl.wash_idex;
   assign hz.mdu_busy     = reset && !hz.exc_flush && (state == MDU_BUSY);
   assign hz.stall_cnt    = stall_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         mdu_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (ctl.pa_pc && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;

         if (hz.exc_flush) begin
            state   <= IDLE;
            mdu_cnt <= '0;
         end else if (!hz.dmem_wait) begin
            case (state)
               MDU_BUSY: begin
                  mdu_cnt <= mdu_cnt - 1'b1;
                  if (mdu_cnt == CNT_W'(1))
                     state <= IDLE;
               end
               default: begin
                  // A one-cycle latency is covered entirely by the issue cycle.
                  if (mdu_issue && (mdu_load != '0)) begin
                     state   <= MDU_BUSY;
                     mdu_cnt <= mdu_load;
                  end
               end
            endcase
         end
      end
   end
endmodule
